// File: rtl/wb_arbiter.sv
// wb_arbiter: merges ALU and load-unit result beats onto one register write port (WB_TRACE_EN adds retire_cnt + trace print).
// Latency: 2 cycles from accept to wb_valid when uncontended; each source buffers 2 beats.
// Backpressure: per-source ready is registered (count < 2); the output stage never stalls.

module wb_fifo2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_dat,
    output logic             rdy,
    input  logic             pop,
    output logic             vld,
    output logic [WIDTH-1:0] head
);
    logic [WIDTH-1:0] store [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;

    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
            rdy    <= 1'b0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count_next;
            // ready follows the post-edge occupancy so it never depends on this cycle's valid
            rdy   <= ~count_next[1];
        end
    end

    always_ff @(posedge clk) begin
        if (push) store[wr_ptr] <= push_dat;
    end

    assign vld  = (count != 2'd0);
    assign head = store[rd_ptr];
endmodule

module wb_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    output logic        alu_ready,
    input  logic [63:0] alu_pc,
    input  logic [4:0]  alu_rd,
    input  logic [63:0] alu_data,
    input  logic        mem_valid,
    output logic        mem_ready,
    input  logic [63:0] mem_pc,
    input  logic [4:0]  mem_rd,
    input  logic [63:0] mem_data,
    output logic        wb_valid,
    output logic [63:0] wb_pc,
    output logic [4:0]  wb_rd,
    output logic [63:0] wb_data,
    output logic [63:0] retire_cnt
);
    typedef struct packed {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
    } beat_t;

    localparam int BW = $bits(beat_t);

    beat_t      alu_head;
    beat_t      mem_head;
    beat_t      sel;
    beat_t      stage;
    logic       alu_vld;
    logic       mem_vld;
    logic       grant_alu;
    logic       grant_mem;
    logic       stage_vld;
    logic [1:0] starve;

    wb_fifo2 #(.WIDTH(BW)) u_alu_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (alu_valid && alu_ready),
        .push_dat ({alu_pc, alu_rd, alu_data}),
        .rdy      (alu_ready),
        .pop      (grant_alu),
        .vld      (alu_vld),
        .head     (alu_head)
    );

    wb_fifo2 #(.WIDTH(BW)) u_mem_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (mem_valid && mem_ready),
        .push_dat ({mem_pc, mem_rd, mem_data}),
        .rdy      (mem_ready),
        .pop      (grant_mem),
        .vld      (mem_vld),
        .head     (mem_head)
    );

    // Loads normally win; an ALU head passed over three times takes the next slot.
    always_comb begin
        grant_alu = alu_vld && (!mem_vld || (starve == 2'd3));
        grant_mem = mem_vld && !grant_alu;
        sel       = grant_alu ? alu_head : mem_head;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve <= 2'd0;
        end else if (!alu_vld || grant_alu) begin
            starve <= 2'd0;
        end else if (starve != 2'd3) begin
            starve <= starve + 2'd1;
        end
    end

    // Writes to x0 are consumed here and never reach the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_vld <= 1'b0;
            stage     <= '0;
        end else begin
            stage_vld <= (grant_alu || grant_mem) && (sel.rd != 5'd0);
            if ((grant_alu || grant_mem) && (sel.rd != 5'd0)) begin
                stage <= sel;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid <= 1'b0;
            wb_pc    <= 64'd0;
            wb_rd    <= 5'd0;
            wb_data  <= 64'd0;
        end else begin
            wb_valid <= stage_vld;
            if (stage_vld) begin
                wb_pc   <= stage.pc;
                wb_rd   <= stage.rd;
                wb_data <= stage.data;
            end
        end
    end

`ifdef WB_TRACE_EN
    logic [63:0] retire_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            retire_q <= 64'd0;
        end else if (wb_valid) begin
            retire_q <= retire_q + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n && wb_valid) begin
            $display("wb retire t=%0t pc=%h data=%h rd=%0d", $time, wb_pc, wb_data, wb_rd);
        end
    end

    assign retire_cnt = retire_q;
`else
    assign retire_cnt = 64'd0;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: every retired write is logged with its cycle and checked
// against hand-computed payloads, latencies and ordering.
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        alu_valid = 1'b0;
    logic        alu_ready;
    logic [63:0] alu_pc = '0;
    logic [4:0]  alu_rd = '0;
    logic [63:0] alu_data = '0;
    logic        mem_valid = 1'b0;
    logic        mem_ready;
    logic [63:0] mem_pc = '0;
    logic [4:0]  mem_rd = '0;
    logic [63:0] mem_data = '0;
    logic        wb_valid;
    logic [63:0] wb_pc;
    logic [4:0]  wb_rd;
    logic [63:0] wb_data;
    logic [63:0] retire_cnt;

`ifdef WB_TRACE_EN
    localparam logic [63:0] EXP_CNT_ONE = 64'd1;
`else
    localparam logic [63:0] EXP_CNT_ONE = 64'd0;
`endif

    wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_pc     (alu_pc),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_pc     (mem_pc),
        .mem_rd     (mem_rd),
        .mem_data   (mem_data),
        .wb_valid   (wb_valid),
        .wb_pc      (wb_pc),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [63:0] pc;
        logic [4:0]  rd;
        logic [63:0] data;
        int          at;
    } ret_t;

    ret_t rq[$];
    ret_t mon;
    always @(negedge clk) begin
        if (wb_valid) begin
            mon.pc = wb_pc; mon.rd = wb_rd; mon.data = wb_data; mon.at = cyc;
            rq.push_back(mon);
        end
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one edge; report which handshakes completed at it.
    task automatic tick(output bit a_acc, output bit m_acc);
        @(negedge clk);
        a_acc = alu_valid && alu_ready;
        m_acc = mem_valid && mem_ready;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit a, m;
        for (int i = 0; i < n; i++) tick(a, m);
    endtask

    task automatic do_reset();
        alu_valid = 1'b0; mem_valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(1);
        rq.delete();
    endtask

    bit a, m;
    int e, na, mc, mr, idx, lat;
    logic [63:0] pcs [3];

    initial begin
        // ---- reset state ----
        repeat (2) @(posedge clk);
        #1;
        check("rst_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("rst_wb_pc", wb_pc, 64'd0);
        check("rst_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("rst_wb_data", wb_data, 64'd0);
        check("rst_retire_cnt", retire_cnt, 64'd0);
        check("rst_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("rst_mem_ready", {63'd0, mem_ready}, 64'd0);
        rst_n = 1'b1;
        idle(1);
        check("rel_alu_ready", {63'd0, alu_ready}, 64'd1);
        check("rel_mem_ready", {63'd0, mem_ready}, 64'd1);
        check("rel_no_wb", rq.size(), 0);

        // ---- single ALU beat, uncontended ----
        rq.delete();
        alu_valid = 1'b1; alu_pc = 64'h1004; alu_rd = 5'd7; alu_data = 64'd8;
        tick(a, m);
        e = cyc;
        check("t25_accept", {63'd0, a}, 64'd1);
        alu_valid = 1'b0;
        idle(6);
        check("t25_count", rq.size(), 1);
        if (rq.size() >= 1) begin
            check("t25_latency", rq[0].at - e, 2);
            check("t25_pc", rq[0].pc, 64'h1004);
            check("t25_rd", {59'd0, rq[0].rd}, 64'd7);
            check("t25_data", rq[0].data, 64'd8);
        end

        // ---- simultaneous ALU and load beats: load first ----
        rq.delete();
        alu_valid = 1'b1; alu_pc = 64'h1000; alu_rd = 5'd5; alu_data = 64'h55;
        mem_valid = 1'b1; mem_pc = 64'h1014; mem_rd = 5'd10; mem_data = 64'h0a0b0c0d01020304;
        tick(a, m);
        e = cyc;
        alu_valid = 1'b0; mem_valid = 1'b0;
        idle(6);
        check("t26_count", rq.size(), 2);
        if (rq.size() >= 2) begin
            check("t26_first_pc", rq[0].pc, 64'h1014);
            check("t26_first_data", rq[0].data, 64'h0a0b0c0d01020304);
            check("t26_first_at", rq[0].at - e, 2);
            check("t26_second_pc", rq[1].pc, 64'h1000);
            check("t26_second_rd", {59'd0, rq[1].rd}, 64'd5);
            check("t26_second_at", rq[1].at - e, 3);
        end

        // ---- continuous loads cannot starve a lone ALU beat ----
        rq.delete();
        mc = 0;
        mem_valid = 1'b1; mem_pc = 64'h3000; mem_rd = 5'd1; mem_data = 64'h33;
        for (int i = 0; i < 3; i++) begin tick(a, m); if (m) mc++; end
        alu_valid = 1'b1; alu_pc = 64'h2000; alu_rd = 5'd9; alu_data = 64'h22;
        tick(a, m); if (m) mc++;
        e = cyc;
        check("t27_accept", {63'd0, a}, 64'd1);
        alu_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin tick(a, m); if (m) mc++; end
        mem_valid = 1'b0;
        idle(6);
        idx = -1; mr = 0;
        foreach (rq[i]) begin
            if (rq[i].pc == 64'h2000) idx = i;
            if (rq[i].rd == 5'd1) mr++;
        end
        check("t27_alu_found", {63'd0, idx >= 0}, 64'd1);
        lat = (idx >= 0) ? rq[idx].at - e : 99;
        check("t27_within_5", {63'd0, lat <= 5 && lat >= 2}, 64'd1);
        check("t27_mem_no_loss", mr, mc);

        // ---- three ALU beats against a saturated load stream ----
        rq.delete();
        mc = 0; na = 0;
        pcs[0] = 64'h4000; pcs[1] = 64'h4004; pcs[2] = 64'h4008;
        mem_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin tick(a, m); if (m) mc++; end
        alu_valid = 1'b1; alu_pc = pcs[0]; alu_rd = 5'd11; alu_data = 64'h400;
        for (int c = 0; c < 40 && na < 3; c++) begin
            tick(a, m);
            if (m) mc++;
            if (a) begin
                na++;
                if (na == 2) check("t28_ready_low", {63'd0, alu_ready}, 64'd0);
                if (na < 3) begin
                    alu_pc = pcs[na]; alu_rd = 5'd11 + 5'(na); alu_data = 64'h400 + 64'(na);
                end else begin
                    alu_valid = 1'b0;
                end
            end
        end
        alu_valid = 1'b0;
        check("t28_all_accepted", na, 3);
        for (int i = 0; i < 4; i++) begin tick(a, m); if (m) mc++; end
        mem_valid = 1'b0;
        idle(8);
        na = 0; mr = 0;
        foreach (rq[i]) begin
            if (rq[i].rd == 5'd1) mr++;
            else if (na < 3) begin
                check("t28_order_pc", rq[i].pc, pcs[na]);
                na++;
            end
        end
        check("t28_alu_retired", na, 3);
        check("t28_mem_no_loss", mr, mc);

        // ---- x0 write is swallowed ----
        do_reset();
        alu_valid = 1'b1; alu_pc = 64'h5000; alu_rd = 5'd0; alu_data = 64'h99;
        tick(a, m);
        alu_pc = 64'h5004; alu_rd = 5'd6; alu_data = 64'ha0b0c0d0e0f01020;
        tick(a, m);
        alu_valid = 1'b0;
        idle(6);
        check("t29_count", rq.size(), 1);
        if (rq.size() >= 1) begin
            check("t29_rd", {59'd0, rq[0].rd}, 64'd6);
            check("t29_data", rq[0].data, 64'ha0b0c0d0e0f01020);
        end
        check("t29_retire_cnt", retire_cnt, EXP_CNT_ONE);

        // ---- asynchronous reset with beats buffered ----
        alu_valid = 1'b1; alu_pc = 64'h6000; alu_rd = 5'd3; alu_data = 64'h66;
        mem_valid = 1'b1; mem_pc = 64'h7000; mem_rd = 5'd4; mem_data = 64'h77;
        idle(6);
        #3;
        rst_n = 1'b0;
        #1;
        check("t30_wb_valid", {63'd0, wb_valid}, 64'd0);
        check("t30_wb_pc", wb_pc, 64'd0);
        check("t30_wb_rd", {59'd0, wb_rd}, 64'd0);
        check("t30_wb_data", wb_data, 64'd0);
        check("t30_alu_ready", {63'd0, alu_ready}, 64'd0);
        check("t30_mem_ready", {63'd0, mem_ready}, 64'd0);
        check("t30_retire_cnt", retire_cnt, 64'd0);
        alu_valid = 1'b0; mem_valid = 1'b0;
        @(posedge clk);
        #1;
        rq.delete();
        rst_n = 1'b1;
        idle(8);
        check("t30_no_wb_after", rq.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
